bht_predictor: RTL and testbench



---
 rtl/bht_predictor.sv | 136 +++++++++++++
 tb/tb_bht_predictor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts next fetch PC, resolves EX outcomes and keeps hit/miss statistics.
module bht_predictor #(
    parameter int IDX_W = 3,
    parameter int TAG_W = 30 - IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_if,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_pc,
    output logic             mispredict,
    output logic [31:0]      correct_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int N = 1 << IDX_W;

    logic             valid_q  [N];
    logic             valid_d  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [TAG_W-1:0] tag_d    [N];
    logic [31:0]      target_q [N];
    logic [31:0]      target_d [N];
    logic [1:0]       ctr_q    [N];
    logic [1:0]       ctr_d    [N];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic unused_bits;
    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

    assign lk_idx = pc_if[IDX_W+1:2];
    assign lk_tag = pc_if[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // Fetch-side lookup: zero-latency prediction from current table contents.
    always_comb begin
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = lk_hit && ctr_q[lk_idx][1];
        pred_pc    = pred_taken ? target_q[lk_idx] : pc_if + 32'd4;
    end

    // EX-side resolution: compare the piped-down prediction with the outcome.
    always_comb begin
        correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        mispredict = upd_valid
                     && ((upd_pred_taken != upd_taken)
                         || (upd_pred_pc != correct_pc));
    end

    // Next-state for the table: train on hit, allocate on taken miss.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    // Next-state for the statistics counters, saturating at all-ones.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_valid && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // State registers; reset clears the table and statistics immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed and random stimulus, reference model,
// expectation queue drained by an independent monitor.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_if = 32'h0000_3000;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_pc = '0;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        pt;
        logic [31:0] ppc;
        logic        mis;
        logic [31:0] cpc;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    // Reference model: one record per table slot, counter as plain integer.
    bit        m_valid [8];
    bit [31:0] m_pc    [8];
    bit [31:0] m_tgt   [8];
    int        m_ctr   [8];
    int        m_bc;
    int        m_mc;

    bht_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc_if         (pc_if),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_pc   (upd_pred_pc),
        .mispredict    (mispredict),
        .correct_pc    (correct_pc),
        .branch_cnt    (branch_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int slot(input bit [31:0] pc);
        return int'(pc[4:2]);
    endfunction

    // A slot matches when it holds a PC with the same upper address bits.
    function automatic bit m_hit(input bit [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && (m_pc[s][31:5] == pc[31:5]);
    endfunction

    function automatic bit m_pt(input bit [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic bit [31:0] m_ppc(input bit [31:0] pc);
        return m_pt(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit [31:0] m_cpc();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        return upd_valid && ((upd_pred_taken != upd_taken)
                             || (upd_pred_pc != m_cpc()));
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.pt  = m_pt(pc_if);
        e.ppc = m_ppc(pc_if);
        e.mis = m_mis();
        e.cpc = m_cpc();
        e.bc  = 16'(m_bc);
        e.mc  = 16'(m_mc);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    // Applies the rules for the inputs held across the current edge.
    task automatic model_update();
        int s;
        if (rst || !upd_valid) return;
        s = slot(upd_pc);
        if (m_mis() && m_mc < 65535) m_mc++;
        if (m_bc < 65535) m_bc++;
        if (m_hit(upd_pc)) begin
            if (upd_taken) begin
                m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_tgt[s] = upd_target;
            end else begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
        end else if (upd_taken) begin
            m_valid[s] = 1;
            m_pc[s]    = upd_pc;
            m_tgt[s]   = upd_target;
            m_ctr[s]   = 2;
        end
    endtask

    task automatic step(input logic r, input logic [31:0] pc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg,
                        input logic upt, input logic [31:0] uppc,
                        input string nm);
        @(posedge clk);
        model_update();
        #1;
        rst = r;
        if (r) model_reset();
        pc_if          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utg;
        upd_pred_taken = upt;
        upd_pred_pc    = uppc;
        exp_q.push_back(expect_now());
        name_q.push_back(nm);
    endtask

    function automatic bit [31:0] rand_pc();
        bit [31:0] base = $urandom_range(0, 1) ? 32'h0000_3000 : 32'h0000_7000;
        return base + (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic rand_step(input string nm);
        bit [31:0] pc  = rand_pc();
        bit [31:0] upc = rand_pc();
        bit        ut  = 1'($urandom_range(0, 1));
        bit [31:0] tg  = rand_pc() + 32'h100;
        bit        uv  = ($urandom_range(0, 3) != 0);
        bit        upt;
        bit [31:0] uppc;
        if ($urandom_range(0, 1) != 0) begin
            upt  = m_pt(upc);
            uppc = m_ppc(upc);
        end else begin
            upt  = 1'($urandom_range(0, 1));
            uppc = upt ? tg : upc + 32'd4;
        end
        step(0, pc, uv, upc, ut, tg, upt, uppc, nm);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare with the queue.
    initial begin
        exp_t a;
        exp_t e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {pred_taken, pred_pc, mispredict, correct_pc,
                      branch_cnt, miss_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got pt=%0b ppc=%h mis=%0b cpc=%h bc=%h mc=%h want pt=%0b ppc=%h mis=%0b cpc=%h bc=%h mc=%h",
                             nm, a.pt, a.ppc, a.mis, a.cpc, a.bc, a.mc,
                             e.pt, e.ppc, e.mis, e.cpc, e.bc, e.mc);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        model_reset();
        step(1, 32'h3000, 0, 0, 0, 0, 0, 0, "reset_state");
        step(0, 32'h3000, 0, 0, 0, 0, 0, 0, "idle_after_reset");
        step(0, 32'h3000, 1, 32'h3010, 1, 32'h3040, 0, 32'h3014,
             "taken_alloc_mispredict");
        step(0, 32'h3010, 0, 0, 0, 0, 0, 0, "hit_after_alloc");
        step(0, 32'h3010, 1, 32'h3010, 0, 32'h3040, 1, 32'h3040,
             "not_taken_1");
        step(0, 32'h3010, 1, 32'h3010, 0, 32'h3040, 0, 32'h3014,
             "not_taken_2");
        step(0, 32'h3010, 1, 32'h3010, 0, 32'h3040, 0, 32'h3014,
             "not_taken_3");
        step(0, 32'h3010, 1, 32'h3010, 1, 32'h3050, 0, 32'h3014,
             "ctr_floor_taken");
        step(0, 32'h3010, 1, 32'h3010, 1, 32'h3060, 0, 32'h3014,
             "retrain_taken");
        step(0, 32'h3010, 1, 32'h3030, 1, 32'h3080, 0, 32'h3034,
             "alias_alloc");
        step(0, 32'h3030, 0, 0, 0, 0, 0, 0, "alias_new_hits");
        step(0, 32'h3010, 0, 0, 0, 0, 0, 0, "alias_old_misses");
        step(0, 32'h3030, 1, 32'h3030, 0, 32'h3080, 1, 32'h3080,
             "same_idx_old_contents");
        step(0, 32'h3030, 0, 0, 0, 0, 0, 0, "same_idx_new_contents");
        step(0, 32'h3ffc, 1, 32'h3ffc, 1, 32'h0000_0000, 0, 32'h4000,
             "target_wrap_alloc");
        step(0, 32'hffff_fffc, 0, 0, 0, 0, 0, 0, "pc_plus4_wrap");
        for (int i = 0; i < 400; i++) rand_step("random");
        for (int i = 0; i < 65600; i++) begin
            step(0, rand_pc(), 1, 32'h3020, 0, 32'h0, 0, 32'h3024,
                 "counter_saturate");
        end
        step(0, 32'h3000, 1, 32'h3024, 1, 32'h3100, 0, 32'h3028,
             "miss_after_sat");
        step(0, 32'h3024, 0, 0, 0, 0, 0, 0, "sat_hold");
        step(1, 32'h3024, 1, 32'h3024, 1, 32'h3200, 0, 32'h3028,
             "reset_midrun");
        step(1, 32'h3024, 0, 0, 0, 0, 0, 0, "reset_held");
        step(0, 32'h3010, 0, 0, 0, 0, 0, 0, "after_reset_miss");
        for (int i = 0; i < 100; i++) rand_step("random_post_reset");
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
